// File: rtl/fta_bus_pkg.sv
// fta_bus_pkg: 128-bit FTA request/response types, I/O arbiter state enum and timer width helpers
package fta_bus_pkg;
  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [7:0]   tid;
    logic [31:0]  padr;
    logic [127:0] dat;
  } fta_cmd_request128_t;
  typedef struct packed {
    logic         ack;
    logic         err;
    logic         rty;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, REPLY} arb_state_e;
  localparam int TIMEOUT_DEF = 255;
  localparam int TIMER_W = $clog2(TIMEOUT_DEF + 1);
  function automatic int timer_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/fta_rr_arbiter.sv
// fta_rr_arbiter: combinational round-robin pick; req vector + ptr in, one-hot gnt, binary idx and any out
module fta_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);
  localparam int IW = $clog2(NREQ);
  logic [IW:0] pos;
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW + 1)'(k);
      pos = pos >= (IW + 1)'(NREQ) ? pos - (IW + 1)'(NREQ) : pos;
      if (req[pos[IW-1:0]]) begin
        idx = pos[IW-1:0];
        any = 1'b1;
      end
    end
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/fta_io_arbiter128.sv
// fta_io_arbiter128: round-robin share of the bridge slave port; req/resp/gnt per requester, m_req/m_resp to bridge, timeout_o pulse, stale_cnt
module fta_io_arbiter128
  import fta_bus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request128_t  req [NREQ],
  output fta_cmd_response128_t resp [NREQ],
  output logic [NREQ-1:0]      gnt,
  output fta_cmd_request128_t  m_req,
  input  fta_cmd_response128_t m_resp,
  output logic                 timeout_o,
  output logic [15:0]          stale_cnt
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = timer_w(TIMEOUT);
  arb_state_e state, state_n;
  logic [NREQ-1:0] cyc_v, sel_gnt, lgnt;
  logic [IW-1:0] sel_idx, idx, ptr;
  logic sel_any, rsp_v, hit, tmo;
  logic [TW-1:0] timer;
  fta_cmd_request128_t lreq;
  fta_cmd_response128_t cap, to_rsp;
  fta_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req(cyc_v),
    .ptr(ptr),
    .gnt(sel_gnt),
    .idx(sel_idx),
    .any(sel_any)
  );
  always_comb begin
    cyc_v = '0;
    for (int k = 0; k < NREQ; k++) cyc_v[k] = req[k].cyc;
  end
  always_comb begin
    rsp_v = m_resp.ack | m_resp.err | m_resp.rty;
    hit = state == WAIT_RESP && rsp_v && m_resp.tid == lreq.tid;
    tmo = state == WAIT_RESP && !hit && timer == TW'(TIMEOUT);
    to_rsp = '0;
    to_rsp.err = 1'b1;
    to_rsp.tid = lreq.tid;
    to_rsp.adr = lreq.padr;
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = sel_any ? ISSUE : IDLE;
      ISSUE:     state_n = WAIT_RESP;
      WAIT_RESP: state_n = (hit || tmo) ? REPLY : WAIT_RESP;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
      idx <= '0;
      lgnt <= '0;
      timer <= '0;
      lreq <= '0;
      cap <= '0;
      stale_cnt <= '0;
    end else begin
      if (state == IDLE && sel_any) begin
        lreq <= req[sel_idx];
        idx <= sel_idx;
        lgnt <= sel_gnt;
      end
      timer <= state == WAIT_RESP ? timer + TW'(1) : '0;
      if (hit) cap <= m_resp;
      else if (tmo) cap <= to_rsp;
      if (rsp_v && !hit && stale_cnt != 16'hFFFF) stale_cnt <= stale_cnt + 16'd1;
      if (state == REPLY) ptr <= idx == IW'(NREQ - 1) ? '0 : idx + IW'(1);
    end
  end
  always_comb begin
    m_req = '0;
    if (state == ISSUE) begin
      m_req = lreq;
      m_req.cyc = 1'b1;
      m_req.stb = 1'b1;
    end
    gnt = state == ISSUE ? lgnt : '0;
    timeout_o = tmo;
    for (int k = 0; k < NREQ; k++) resp[k] = (state == REPLY && idx == IW'(k)) ? cap : '0;
  end
endmodule

// File: tb/tb_fta_io_arbiter128.sv
// tb_fta_io_arbiter128: directed bench with a transaction-level reference model checked every cycle
module tb_fta_io_arbiter128;
  import fta_bus_pkg::*;
  localparam int NREQ = 4;
  localparam int TMO = 8;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  fta_cmd_request128_t req [NREQ];
  fta_cmd_response128_t resp [NREQ];
  logic [NREQ-1:0] gnt;
  fta_cmd_request128_t m_req;
  fta_cmd_response128_t m_resp;
  logic timeout_o;
  logic [15:0] stale_cnt;
  int checks = 0;
  int errors = 0;
  fta_io_arbiter128 #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .req(req),
    .resp(resp),
    .gnt(gnt),
    .m_req(m_req),
    .m_resp(m_resp),
    .timeout_o(timeout_o),
    .stale_cnt(stale_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  // reference model: whole transactions tracked by cycle numbers (grant, issue, reply)
  int now = 0;
  int owner = -1;
  int issue_at = -1;
  int reply_at = -1;
  int ptr_m = 0;
  int stale_m = 0;
  bit ok = 0;
  fta_cmd_request128_t lat;
  fta_cmd_response128_t exp_r;
  initial begin : model
    bit rv, waiting, match, tmo, found;
    fta_cmd_request128_t em;
    logic [NREQ-1:0] eg;
    int j;
    forever begin
      @(negedge clk);
      rv = m_resp.ack | m_resp.err | m_resp.rty;
      waiting = owner >= 0 && now > issue_at && reply_at < 0;
      match = waiting && rv && m_resp.tid == lat.tid;
      tmo = waiting && !match && (now - issue_at - 1 == TMO);
      if (ok) begin
        em = '0;
        eg = '0;
        if (owner >= 0 && now == issue_at) begin
          em = lat;
          em.cyc = 1'b1;
          em.stb = 1'b1;
          eg[owner] = 1'b1;
        end
        check("m_req", 256'(m_req), 256'(em));
        check("gnt", 256'(gnt), 256'(eg));
        for (int i = 0; i < NREQ; i++)
          check($sformatf("resp%0d", i), 256'(resp[i]),
                (now == reply_at && i == owner) ? 256'(exp_r) : 256'(0));
        check("timeout_o", 256'(timeout_o), 256'(tmo));
        check("stale_cnt", 256'(stale_cnt), 256'(stale_m));
      end
      if (rst_i) begin
        owner = -1;
        issue_at = -1;
        reply_at = -1;
        ptr_m = 0;
        stale_m = 0;
        ok = 1;
      end else if (ok) begin
        if (rv && !match && stale_m < 65535) stale_m++;
        if (match) begin
          exp_r = m_resp;
          reply_at = now + 1;
        end else if (tmo) begin
          exp_r = '0;
          exp_r.err = 1'b1;
          exp_r.tid = lat.tid;
          exp_r.adr = lat.padr;
          reply_at = now + 1;
        end
        if (now == reply_at) begin
          ptr_m = (owner + 1) % NREQ;
          owner = -1;
          reply_at = -1;
        end else if (owner < 0) begin
          found = 0;
          for (int k = 0; k < NREQ; k++) begin
            j = (ptr_m + k) % NREQ;
            if (!found && req[j].cyc) begin
              found = 1;
              owner = j;
            end
          end
          if (found) begin
            lat = req[owner];
            issue_at = now + 1;
          end
        end
      end
      now++;
    end
  end
  function automatic fta_cmd_request128_t mk(input logic [7:0] tid, input logic [31:0] a);
    fta_cmd_request128_t r;
    r = '0;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    r.sel = '1;
    r.tid = tid;
    r.padr = a;
    r.dat = {4{a}};
    return r;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] tid, input logic [127:0] dat, input logic a, input logic e, input logic r);
    m_resp = '0;
    m_resp.ack = a;
    m_resp.err = e;
    m_resp.rty = r;
    m_resp.tid = tid;
    m_resp.adr = 32'hB000_0000;
    m_resp.dat = dat;
    tick();
    m_resp = '0;
  endtask
  task automatic wait_gnt(input int who, output int n);
    n = 0;
    @(negedge clk);
    while (gnt[who] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gnt_seen", 256'(gnt[who]), 256'(1));
    tick();
  endtask
  task automatic wait_any(output int who);
    int n;
    n = 0;
    who = -1;
    @(negedge clk);
    while (gnt == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < NREQ; i++) if (gnt[i]) who = i;
    check("gnt_any", 256'(gnt != 0), 256'(1));
    tick();
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    m_resp = '0;
    tick();
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_stale", 256'(stale_cnt), 256'(0));
    check("rst_gnt", 256'(gnt), 256'(0));
    check("rst_mreq", 256'(m_req), 256'(0));
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int n, who, k;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    m_resp = '0;
    do_reset();
    // single read by requester 2, bridge answers on the third wait cycle
    req[2] = mk(8'd5, 32'hF000_0010);
    wait_gnt(2, n);
    req[2].cyc = 1'b0;
    check("t1_gnt_lat", 256'(n), 256'(1));
    tick();
    tick();
    send(8'd5, {4{32'h1234_5678}}, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_ack", 256'(resp[2].ack), 256'(1));
    check("t1_tid", 256'(resp[2].tid), 256'(5));
    check("t1_dat", 256'(resp[2].dat), 256'({4{32'h1234_5678}}));
    check("t1_r0", 256'(resp[0]), 256'(0));
    tick();
    // all requesters held active: strict rotation from pointer 0
    do_reset();
    for (int i = 0; i < NREQ; i++) req[i] = mk(8'h10 + 8'(i), 32'hF000_0000 + 32'(i * 16));
    for (int g = 0; g < 5; g++) begin
      wait_any(who);
      check($sformatf("t2_order%0d", g), 256'(who), 256'(exp_order[g]));
      send(8'h10 + 8'(who), 128'(g), 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < NREQ; i++) req[i] = '0;
    tick();
    // silent bridge: synthesized err, then a late ack counted as stale
    do_reset();
    req[1] = mk(8'd9, 32'hF000_0100);
    wait_gnt(1, n);
    req[1].cyc = 1'b0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout_o) break;
      tick();
    end
    check("t3_to_delay", 256'(k), 256'(TMO));
    tick();
    @(negedge clk);
    check("t3_err", 256'(resp[1].err), 256'(1));
    check("t3_ack", 256'(resp[1].ack), 256'(0));
    check("t3_tid", 256'(resp[1].tid), 256'(9));
    check("t3_adr", 256'(resp[1].adr), 256'(32'hF000_0100));
    tick();
    send(8'd9, 128'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_stale", 256'(stale_cnt), 256'(1));
    tick();
    // wrong tid dropped, right tid completes
    do_reset();
    req[3] = mk(8'd5, 32'hF000_0200);
    wait_gnt(3, n);
    req[3].cyc = 1'b0;
    send(8'd7, 128'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_stale", 256'(stale_cnt), 256'(1));
    check("t4_noresp", 256'(resp[3]), 256'(0));
    tick();
    send(8'd5, 128'hCAFE, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_ack", 256'(resp[3].ack), 256'(1));
    check("t4_tid", 256'(resp[3].tid), 256'(5));
    check("t4_stale2", 256'(stale_cnt), 256'(1));
    tick();
    // reset while waiting: transaction abandoned, its reply is stale
    do_reset();
    req[0] = mk(8'd3, 32'hF000_0300);
    wait_gnt(0, n);
    req[0].cyc = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("t5_mreq", 256'(m_req), 256'(0));
    check("t5_stale0", 256'(stale_cnt), 256'(0));
    tick();
    send(8'd3, 128'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t5_stale1", 256'(stale_cnt), 256'(1));
    check("t5_noresp", 256'(resp[0]), 256'(0));
    tick();
    tick();
    // ack on the very cycle the timer expires wins over the timeout
    do_reset();
    req[1] = mk(8'd4, 32'hF000_0400);
    wait_gnt(1, n);
    req[1].cyc = 1'b0;
    repeat (TMO) tick();
    m_resp = '0;
    m_resp.ack = 1'b1;
    m_resp.tid = 8'd4;
    @(negedge clk);
    check("t6_no_to", 256'(timeout_o), 256'(0));
    tick();
    m_resp = '0;
    @(negedge clk);
    check("t6_ack", 256'(resp[1].ack), 256'(1));
    check("t6_err", 256'(resp[1].err), 256'(0));
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fta_io_arbiter128.md
Name: fta_io_arbiter128

Overview:
Shares the single 128-bit slave port of the 128-to-32 I/O bridge between NREQ 128-bit FTA requesters (CPU cores, DMA, debug).
- Arbitrates round-robin and issues exactly one single-cycle command per grant.
- Tracks the outstanding transaction by tid and routes the bridge response back to the owning requester.
- Synthesizes an error response if the I/O device never answers.
- Sits between the requester fabric and the bridge's s1_req/s1_resp.

Parameters:
NREQ, 4, number of requester ports (2..8)
TIMEOUT, 255, cycles waited in WAIT_RESP before a synthesized err response (1..65535)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; one clock, synchronous, active-high
req  input  fta_cmd_request128_t[NREQ]  requester commands; a requester holds cyc and contents until it sees gnt
resp  output  fta_cmd_response128_t[NREQ]  per-requester responses
gnt  output  NREQ  one-cycle pulse: request captured
m_req  output  fta_cmd_request128_t  to the bridge slave request
m_resp  input  fta_cmd_response128_t  from the bridge slave response
timeout_o  output  1  one-cycle pulse when a timeout error is synthesized
stale_cnt  output  16  saturating count of discarded responses

Behaviour:
- Reset values:
  - state=IDLE, rr pointer=0, timer=0.
  - gnt=0, timeout_o=0, stale_cnt=0.
  - m_req all zero.
  - every resp all zero.
- States: IDLE, ISSUE, WAIT_RESP, REPLY.
- IDLE:
  - Select the first requester with req[i].cyc=1, searching from pointer upward with wrap.
  - Latch its full request and index.
  - Next state ISSUE. If no requester is active, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - m_req = latched request with cyc=1 and stb=1; gnt[idx]=1.
  - timer=0. Next state WAIT_RESP.
  - m_req is zero in every other state, so the bridge sees one command per grant.
- WAIT_RESP:
  - timer increments each cycle.
  - If m_resp has ack, err or rty set and m_resp.tid == latched tid: capture the response, go to REPLY.
  - Else if timer == TIMEOUT: build a response with err=1, tid=latched tid, adr=latched padr, dat=0; pulse timeout_o; go to REPLY.
  - A matching response in the same cycle as timer==TIMEOUT wins; no timeout_o in that case.
- REPLY (1 cycle):
  - resp[idx] = captured response; all other resp are zero.
  - pointer = idx+1, wrapping modulo NREQ.
  - Next state IDLE.
- Grant-to-regrant is at least 4 cycles, so a requester still holding cyc after gnt is not regranted before REPLY. Fairness: a requester waits at most NREQ-1 grants.
- rty responses are passed through unchanged; retrying is the requester's job.
- Stale responses: any m_resp with ack/err/rty whose tid does not match, or that arrives in a state other than WAIT_RESP (including a late reply after a timeout), is dropped and stale_cnt increments. stale_cnt saturates at 16'hFFFF.
- A response arriving in the same cycle as ISSUE is treated as stale.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - The in-flight transaction is abandoned; no resp is produced.
  - Its eventual bridge reply counts as stale.
- Latency:
  - cyc seen in IDLE at cycle N gives m_req at N+1.
  - A bridge reply at cycle M gives resp at M+1.

Decomposition:
- fta_bus_pkg already provides the request and response types. Add to it the arbiter state enum and the localparam for the timer width, $clog2(TIMEOUT+1).
- Sub-module fta_rr_arbiter: parameterised NREQ. Inputs are the request vector and pointer; outputs are a one-hot grant and the binary index. Purely combinational, reusable elsewhere.

Test Plan:
1. NREQ=4; only req[2] issues a read, tid=5, bridge acks after 3 cycles with dat=32'h1234_5678 replicated → gnt[2] at N+1, single-cycle m_req.cyc, resp[2].ack=1 with tid=5, other resp zero.
2. req[0..3] all asserted continuously with pointer=0 → grants in order 0,1,2,3,0; no requester is granted twice before the others.
3. Bridge never responds, TIMEOUT=8 → resp[idx].err=1 and timeout_o pulse exactly 8 cycles after ISSUE; a late ack with the same tid then increments stale_cnt to 1.
4. Bridge returns ack with tid=7 while the latched tid=5 → stale_cnt=1, state stays WAIT_RESP; the correct tid=5 ack then completes normally.
5. rst_i asserted during WAIT_RESP → all outputs zero the next cycle, state IDLE; the subsequent bridge ack counts as stale and no resp is produced.
6. Matching ack arrives on the exact cycle timer==TIMEOUT → resp carries ack=1 and err=0; timeout_o stays 0.
